// File: rtl/wu_event_logger.sv
// ---------------------------------------------------------------------------
// wu_event_logger
//
// Purpose:
//   Timestamps every rising edge of trig_to_siggen against the chip's
//   wake_up (and optionally comp_out) response.  Each outcome is written as a
//   32-bit record into an on-chip FIFO that the pipe-out side drains.
//
//   Record layout: [31:30] type, [29:24] seq, [23:0] latency
//     type 00 = HIT, 01 = MISS, 10 = STAGE2, 11 = FALSE_POS
//
// Optional feature macro:
//   WU_LOG_STAGE2_EN - when defined, a HIT is followed by a STAGE2 state that
//   measures the comp_out response.  When undefined, comp_out is ignored and
//   type 10 records are never produced.
//
// Parameters:
//   ADDR_W  - FIFO address width, depth = 2**ADDR_W records
//   WINDOW  - response window in clki cycles (1 .. 2**24-1)
//
// Ports:
//   clki           in   system clock
//   reset          in   synchronous, active-high reset
//   trig_to_siggen in   trigger pulse, synchronous to clki
//   wake_up        in   chip wake-up output, asynchronous
//   comp_out       in   chip comparator output, asynchronous
//   rd_en          in   FIFO pop request
//   rd_data        out  popped record (registered)
//   rd_valid       out  rd_data updated this cycle
//   empty          out  FIFO empty
//   full           out  FIFO full
//   level          out  current record count
//   drop_cnt       out  records lost to overflow, saturating
//   o_dbg_state    out  FSM state (0 IDLE, 1 ARMED, 2 STAGE2)
//
// Read handshake:
//   rd_en is a pop request sampled on the rising clock edge.  It is honoured
//   only when the FIFO is not empty.  An honoured pop raises rd_valid for
//   exactly the following cycle, with rd_data holding the record; a pop on
//   an empty FIFO leaves rd_valid low and rd_data unchanged.  The write side
//   has no backpressure: a record pushed into a full FIFO without a
//   simultaneous pop is dropped and counted in drop_cnt.
// ---------------------------------------------------------------------------
module wu_event_logger #(
    parameter int          ADDR_W = 9,
    parameter logic [23:0] WINDOW = 24'd1_000_000
) (
    input  logic              clki,
    input  logic              reset,
    input  logic              trig_to_siggen,
    input  logic              wake_up,
    input  logic              comp_out,
    input  logic              rd_en,
    output logic [31:0]       rd_data,
    output logic              rd_valid,
    output logic              empty,
    output logic              full,
    output logic [ADDR_W:0]   level,
    output logic [15:0]       drop_cnt,
    output logic [1:0]        o_dbg_state
);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ARMED  = 2'd1,
        ST_STAGE2 = 2'd2
    } state_t;

    localparam logic [1:0] TYPE_HIT       = 2'b00;
    localparam logic [1:0] TYPE_MISS      = 2'b01;
    localparam logic [1:0] TYPE_STAGE2    = 2'b10;
    localparam logic [1:0] TYPE_FALSE_POS = 2'b11;

    localparam int            DEPTH_N = 1 << ADDR_W;
    localparam logic [ADDR_W:0] DEPTH = {1'b1, {ADDR_W{1'b0}}};

    // -----------------------------------------------------------------------
    // Input conditioning
    // -----------------------------------------------------------------------
    logic r_trig_d;
    logic r_wu_s1, r_wu_s2, r_wu_d, r_wu_edge;
    logic w_trig_edge;

    assign w_trig_edge = trig_to_siggen & ~r_trig_d;

    // wake_up: 2-flop synchroniser, then a registered rising-edge pulse.
    // The edge register is what puts the wake path 2 cycles behind the
    // trigger path; reported latencies include that offset.
    always_ff @(posedge clki) begin
        if (reset) begin
            r_trig_d  <= 1'b0;
            r_wu_s1   <= 1'b0;
            r_wu_s2   <= 1'b0;
            r_wu_d    <= 1'b0;
            r_wu_edge <= 1'b0;
        end else begin
            r_trig_d  <= trig_to_siggen;
            r_wu_s1   <= wake_up;
            r_wu_s2   <= r_wu_s1;
            r_wu_d    <= r_wu_s2;
            r_wu_edge <= r_wu_s2 & ~r_wu_d;
        end
    end

`ifdef WU_LOG_STAGE2_EN
    logic r_co_s1, r_co_s2, r_co_d, r_co_edge;

    always_ff @(posedge clki) begin
        if (reset) begin
            r_co_s1   <= 1'b0;
            r_co_s2   <= 1'b0;
            r_co_d    <= 1'b0;
            r_co_edge <= 1'b0;
        end else begin
            r_co_s1   <= comp_out;
            r_co_s2   <= r_co_s1;
            r_co_d    <= r_co_s2;
            r_co_edge <= r_co_s2 & ~r_co_d;
        end
    end
`else
    logic w_unused_comp;
    assign w_unused_comp = comp_out;
`endif

    // -----------------------------------------------------------------------
    // Measurement FSM
    // -----------------------------------------------------------------------
    state_t      r_state, w_state_nxt;
    logic [5:0]  r_seq, w_seq_nxt;
    logic [23:0] r_lat, w_lat_nxt;
    logic        w_push;
    logic [31:0] w_push_rec;
`ifdef WU_LOG_STAGE2_EN
    logic [23:0] r_lat2, w_lat2_nxt;
`endif

    always_ff @(posedge clki) begin
        if (reset) begin
            r_state <= ST_IDLE;
            r_seq   <= 6'd0;
            r_lat   <= 24'd0;
        end else begin
            r_state <= w_state_nxt;
            r_seq   <= w_seq_nxt;
            r_lat   <= w_lat_nxt;
        end
    end

`ifdef WU_LOG_STAGE2_EN
    always_ff @(posedge clki) begin
        if (reset) begin
            r_lat2 <= 24'd0;
        end else begin
            r_lat2 <= w_lat2_nxt;
        end
    end
`endif

    always_comb begin
        w_state_nxt = r_state;
        w_seq_nxt   = r_seq;
        w_lat_nxt   = r_lat;
        w_push      = 1'b0;
        w_push_rec  = 32'd0;
`ifdef WU_LOG_STAGE2_EN
        w_lat2_nxt  = r_lat2;
`endif
        case (r_state)
            ST_IDLE: begin
                // A wake-up with no measurement open is a false positive.
                // It can share a cycle with a trigger: the record carries
                // the pre-trigger seq and the FSM still arms.
                if (r_wu_edge) begin
                    w_push     = 1'b1;
                    w_push_rec = {TYPE_FALSE_POS, r_seq, 24'd0};
                end
                if (w_trig_edge) begin
                    w_state_nxt = ST_ARMED;
                    w_lat_nxt   = 24'd0;
                    w_seq_nxt   = r_seq + 6'd1;
                end
            end

            ST_ARMED: begin
                w_lat_nxt = r_lat + 24'd1;
                if (r_wu_edge) begin
                    // HIT wins over both a new trigger and the timeout.
                    w_push     = 1'b1;
                    w_push_rec = {TYPE_HIT, r_seq, r_lat};
`ifdef WU_LOG_STAGE2_EN
                    w_state_nxt = ST_STAGE2;
                    // The HIT detect cycle counts as lat2 = 0, so the
                    // register already holds 1 in the following cycle.
                    w_lat2_nxt  = 24'd1;
`else
                    w_state_nxt = ST_IDLE;
`endif
                end else if (w_trig_edge) begin
                    // Retrigger before a response: close this seq as MISS
                    // with the latency reached so far.
                    w_push     = 1'b1;
                    w_push_rec = {TYPE_MISS, r_seq, r_lat};
                end else if (r_lat == WINDOW - 24'd1) begin
                    w_push      = 1'b1;
                    w_push_rec  = {TYPE_MISS, r_seq, WINDOW};
                    w_state_nxt = ST_IDLE;
                end
                // A trigger always rearms, whatever was pushed above.
                if (w_trig_edge) begin
                    w_state_nxt = ST_ARMED;
                    w_lat_nxt   = 24'd0;
                    w_seq_nxt   = r_seq + 6'd1;
                end
            end

`ifdef WU_LOG_STAGE2_EN
            ST_STAGE2: begin
                w_lat2_nxt = r_lat2 + 24'd1;
                if (w_trig_edge) begin
                    // Abandon the stage-2 measurement silently and rearm.
                    w_state_nxt = ST_ARMED;
                    w_lat_nxt   = 24'd0;
                    w_seq_nxt   = r_seq + 6'd1;
                end else if (r_co_edge) begin
                    w_push      = 1'b1;
                    w_push_rec  = {TYPE_STAGE2, r_seq, r_lat2};
                    w_state_nxt = ST_IDLE;
                end else if (r_lat2 >= WINDOW - 24'd1) begin
                    // >= rather than == because lat2 starts at 1.
                    w_state_nxt = ST_IDLE;
                end
            end
`endif

            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    assign o_dbg_state = r_state;

    // -----------------------------------------------------------------------
    // Record FIFO
    // -----------------------------------------------------------------------
    logic [31:0]       r_mem [0:DEPTH_N-1];
    logic [ADDR_W-1:0] r_wr_ptr, r_rd_ptr;
    logic [ADDR_W:0]   r_level;
    logic [31:0]       r_rd_data;
    logic              r_rd_valid;
    logic [15:0]       r_drop_cnt;
    logic              w_full, w_empty, w_pop, w_wr_en, w_drop;

    assign w_full  = (r_level == DEPTH);
    assign w_empty = (r_level == '0);
    assign w_pop   = rd_en & ~w_empty;
    // A pop in the same cycle frees the slot the push needs.
    assign w_wr_en = w_push & (~w_full | w_pop);
    assign w_drop  = w_push & w_full & ~w_pop;

    always_ff @(posedge clki) begin
        if (w_wr_en) begin
            r_mem[r_wr_ptr] <= w_push_rec;
        end
    end

    always_ff @(posedge clki) begin
        if (reset) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_level    <= '0;
            r_rd_data  <= 32'd0;
            r_rd_valid <= 1'b0;
            r_drop_cnt <= 16'd0;
        end else begin
            r_rd_valid <= w_pop;
            if (w_wr_en) begin
                r_wr_ptr <= r_wr_ptr + ADDR_W'(1);
            end
            if (w_pop) begin
                r_rd_data <= r_mem[r_rd_ptr];
                r_rd_ptr  <= r_rd_ptr + ADDR_W'(1);
            end
            case ({w_wr_en, w_pop})
                2'b10:   r_level <= r_level + (ADDR_W+1)'(1);
                2'b01:   r_level <= r_level - (ADDR_W+1)'(1);
                default: r_level <= r_level;
            endcase
            if (w_drop && (r_drop_cnt != 16'hFFFF)) begin
                r_drop_cnt <= r_drop_cnt + 16'd1;
            end
        end
    end

    assign rd_data  = r_rd_data;
    assign rd_valid = r_rd_valid;
    assign empty    = w_empty;
    assign full     = w_full;
    assign level    = r_level;
    assign drop_cnt = r_drop_cnt;

endmodule

// File: tb/tb_wu_event_logger.sv
// ---------------------------------------------------------------------------
// tb_wu_event_logger
//
// Directed bench for wu_event_logger with a 4-deep FIFO (ADDR_W = 2) and a
// 1200-cycle response window.  Inputs change on the falling edge and outputs
// are sampled on the falling edge.  Expected records are hand-computed from
// the trigger/response spacing used in each step.
// ---------------------------------------------------------------------------
module tb_wu_event_logger;

    localparam int          ADDR_W = 2;
    localparam logic [23:0] WINDOW = 24'd1200;

    localparam logic [1:0] T_HIT = 2'b00;
    localparam logic [1:0] T_MISS = 2'b01;
    localparam logic [1:0] T_STAGE2 = 2'b10;
    localparam logic [1:0] T_FP = 2'b11;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_ARMED = 2'd1;

    logic              clki = 1'b0;
    logic              reset;
    logic              trig;
    logic              wake;
    logic              comp;
    logic              rd_en;
    logic [31:0]       rd_data;
    logic              rd_valid;
    logic              empty;
    logic              full;
    logic [ADDR_W:0]   level;
    logic [15:0]       drop_cnt;
    logic [1:0]        dbg_state;

    int n_chk = 0;
    int n_err = 0;

    wu_event_logger #(
        .ADDR_W (ADDR_W),
        .WINDOW (WINDOW)
    ) dut (
        .clki           (clki),
        .reset          (reset),
        .trig_to_siggen (trig),
        .wake_up        (wake),
        .comp_out       (comp),
        .rd_en          (rd_en),
        .rd_data        (rd_data),
        .rd_valid       (rd_valid),
        .empty          (empty),
        .full           (full),
        .level          (level),
        .drop_cnt       (drop_cnt),
        .o_dbg_state    (dbg_state)
    );

    always #5 clki = ~clki;

    function automatic logic [31:0] rec(input logic [1:0] t, input logic [5:0] s,
                                        input logic [23:0] l);
        return {t, s, l};
    endfunction

    task automatic tick(input int n);
        repeat (n) @(negedge clki);
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Bounded wait for the FIFO to reach a level; an expired budget shows up
    // as a failed level comparison.
    task automatic wait_level(input int target, input int budget, input string tag);
        int k;
        k = 0;
        while ((int'(level) != target) && (k < budget)) begin
            tick(1);
            k++;
        end
        chk(tag, 32'(level), 32'(target));
    endtask

    task automatic pop_chk(input string tag, input logic [31:0] exp);
        rd_en = 1'b1;
        tick(1);
        rd_en = 1'b0;
        chk({tag, "_vld"}, 32'(rd_valid), 32'd1);
        chk(tag, rd_data, exp);
    endtask

    task automatic trig_pulse();
        trig = 1'b1;
        tick(1);
        trig = 1'b0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1;
        trig  = 1'b0;
        wake  = 1'b0;
        comp  = 1'b0;
        rd_en = 1'b0;
        tick(3);

        // ---- reset state ----
        chk("rst_empty", 32'(empty), 32'd1);
        chk("rst_full", 32'(full), 32'd0);
        chk("rst_level", 32'(level), 32'd0);
        chk("rst_rd_valid", 32'(rd_valid), 32'd0);
        chk("rst_rd_data", rd_data, 32'd0);
        chk("rst_drop", 32'(drop_cnt), 32'd0);
        chk("rst_state", 32'(dbg_state), 32'(S_IDLE));
        reset = 1'b0;
        tick(2);

        // ---- false positive before any trigger: seq 0, latency 0 ----
        wake = 1'b1;
        tick(1);
        wake = 1'b0;
        wait_level(1, 10, "fp_level");
        pop_chk("fp_rec", rec(T_FP, 6'd0, 24'd0));
        chk("fp_empty", 32'(empty), 32'd1);

        // ---- pop on empty: ignored, data held ----
        rd_en = 1'b1;
        tick(1);
        rd_en = 1'b0;
        chk("pop_empty_vld", 32'(rd_valid), 32'd0);
        chk("pop_empty_hold", rd_data, rec(T_FP, 6'd0, 24'd0));

        // ---- overflow: 6 pushes into a 4-deep FIFO ----
        for (int i = 0; i < 6; i++) begin
            wake = 1'b1;
            tick(1);
            wake = 1'b0;
            tick(3);
        end
        tick(2);
        chk("ovf_level", 32'(level), 32'd4);
        chk("ovf_full", 32'(full), 32'd1);
        chk("ovf_empty", 32'(empty), 32'd0);
        chk("ovf_drop", 32'(drop_cnt), 32'd2);

        // ---- push and pop in the same cycle while full ----
        wake = 1'b1;
        tick(1);
        wake = 1'b0;
        tick(2);
        rd_en = 1'b1;
        tick(1);
        rd_en = 1'b0;
        chk("pp_vld", 32'(rd_valid), 32'd1);
        chk("pp_data", rd_data, rec(T_FP, 6'd0, 24'd0));
        chk("pp_level", 32'(level), 32'd4);
        chk("pp_drop", 32'(drop_cnt), 32'd2);
        chk("pp_full", 32'(full), 32'd1);

        // ---- reset with records stored: everything cleared ----
        reset = 1'b1;
        tick(2);
        reset = 1'b0;
        chk("rst2_level", 32'(level), 32'd0);
        chk("rst2_empty", 32'(empty), 32'd1);
        chk("rst2_drop", 32'(drop_cnt), 32'd0);
        chk("rst2_rd_data", rd_data, 32'd0);
        tick(2);

        // ---- HIT: wake_up 1000 cycles after trigger -> latency 1002 ----
        trig_pulse();
        tick(999);
        chk("hit_armed", 32'(dbg_state), 32'(S_ARMED));
        wake = 1'b1;
        wait_level(1, 10, "hit_level");
        wake = 1'b0;
`ifndef WU_LOG_STAGE2_EN
        chk("hit_idle", 32'(dbg_state), 32'(S_IDLE));
`endif
        pop_chk("hit_rec", rec(T_HIT, 6'd1, 24'd1002));

        // ---- MISS: no response within the window -> latency WINDOW ----
        trig_pulse();
        wait_level(1, 1300, "miss_level");
        chk("miss_idle", 32'(dbg_state), 32'(S_IDLE));
        pop_chk("miss_rec", rec(T_MISS, 6'd2, WINDOW));

        // ---- retrigger 200 cycles in; then HIT coinciding with a trigger ----
        trig_pulse();
        tick(199);
        trig_pulse();
        chk("retrig_level", 32'(level), 32'd1);
        chk("retrig_armed", 32'(dbg_state), 32'(S_ARMED));
        tick(50);
        wake = 1'b1;
        tick(1);
        wake = 1'b0;
        tick(2);
        trig_pulse();
        wait_level(3, 1300, "retrig_level3");
        chk("retrig_idle", 32'(dbg_state), 32'(S_IDLE));
        pop_chk("retrig_miss", rec(T_MISS, 6'd3, 24'd199));
        pop_chk("coinc_hit", rec(T_HIT, 6'd4, 24'd53));
        pop_chk("coinc_rearm_miss", rec(T_MISS, 6'd5, WINDOW));

        // ---- 59 more triggers (64 total): seq wraps to 0 ----
        for (int i = 0; i < 59; i++) begin
            trig_pulse();
            tick(1);
        end
        chk("wrap_drop", 32'(drop_cnt), 32'd54);
        chk("wrap_level", 32'(level), 32'd4);
        chk("wrap_full", 32'(full), 32'd1);
        chk("wrap_armed", 32'(dbg_state), 32'(S_ARMED));
        rd_en = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick(1);
            chk("b2b_vld", 32'(rd_valid), 32'd1);
            chk("b2b_rec", rd_data, rec(T_MISS, 6'(6 + i), 24'd1));
        end
        rd_en = 1'b0;
        chk("b2b_empty", 32'(empty), 32'd1);
        wake = 1'b1;
        tick(1);
        wake = 1'b0;
        wait_level(1, 10, "wrap_hit_level");
        pop_chk("wrap_hit", rec(T_HIT, 6'd0, 24'd8));

`ifdef WU_LOG_STAGE2_EN
        // ---- stage 2: wake_up at +100, comp_out at +350 ----
        trig_pulse();
        tick(99);
        wake = 1'b1;
        tick(1);
        wake = 1'b0;
        tick(249);
        comp = 1'b1;
        tick(1);
        comp = 1'b0;
        wait_level(2, 20, "s2_level");
        pop_chk("s2_hit", rec(T_HIT, 6'd1, 24'd102));
        pop_chk("s2_rec", rec(T_STAGE2, 6'd1, 24'd250));
        chk("s2_idle", 32'(dbg_state), 32'(S_IDLE));
`endif

        tick(2);
        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
